// File: rtl/mux_nto1_scan_if.sv
// rtl/mux_nto1_scan_if.sv - select/handshake bundle for mux_nto1_scan; out_par present under MUX_PARITY_EN
interface mux_nto1_scan_if #(
    parameter int N     = 6,
    parameter int W     = 1,
    parameter int SEL_W = 3
);
    logic [N*W-1:0]   in_data;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic             req;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_idx;
    logic             busy;
    logic             done;
`ifdef MUX_PARITY_EN
    logic             out_par;
`endif

    modport master (
        output in_data, sel, mode, req, start, out_ready,
        input  out_valid, out_data, out_idx, busy, done
`ifdef MUX_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  in_data, sel, mode, req, start, out_ready,
        output out_valid, out_data, out_idx, busy, done
`ifdef MUX_PARITY_EN
        , output out_par
`endif
    );
endinterface

// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - registered N:1 mux with direct load and auto-scan; MUX_PARITY_EN adds out_par
module mux_nto1_scan #(
    parameter int N     = 6,
    parameter int W     = 1,
    parameter int SEL_W = 3
) (
    input logic            clk,
    input logic            rst,
    mux_nto1_scan_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N-1);

    state_t           state, state_nxt;
    logic [SEL_W:0]   cnt;
    logic             free;
    logic             load;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             done_c;
    logic [SEL_W-1:0] sel_clamped;
    logic [SEL_W-1:0] load_idx;
    logic [W-1:0]     load_data;

    assign free        = !bus.out_valid || bus.out_ready;
    assign sel_clamped = ({1'b0, bus.sel} >= N_EXT) ? LAST : bus.sel;
    assign load_data   = bus.in_data[int'(load_idx)*W +: W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // cnt reaching N means every input has been captured; only the final beat is still pending
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = sel_clamped;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mode) begin
                    if (bus.start) begin
                        state_nxt = SCAN;
                        cnt_clr   = 1'b1;
                    end
                end else if (bus.req && free) begin
                    load = 1'b1;
                end
            end
            SCAN: begin
                if (cnt == N_EXT) begin
                    if (bus.out_valid && bus.out_ready) begin
                        done_c    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (free) begin
                    load     = 1'b1;
                    load_idx = cnt[SEL_W-1:0];
                    cnt_inc  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_inc) cnt <= cnt + (SEL_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
`ifdef MUX_PARITY_EN
            bus.out_par   <= 1'b0;
`endif
        end else if (free) begin
            bus.out_valid <= load;
            if (load) begin
                bus.out_data <= load_data;
                bus.out_idx  <= load_idx;
`ifdef MUX_PARITY_EN
                bus.out_par  <= ^load_data;
`endif
            end
        end
    end

    assign bus.busy = (state == SCAN);
    assign bus.done = done_c;
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb/tb_mux_nto1_scan.sv - directed vectors and scan sequences for mux_nto1_scan (N=6, W=4)
module tb_mux_nto1_scan;
    localparam int N     = 6;
    localparam int W     = 4;
    localparam int SEL_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_nto1_scan_if #(.N(N), .W(W), .SEL_W(SEL_W)) bus ();

    mux_nto1_scan #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [23:0] in_data;
        logic [3:0]  exp_data;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vecs[7];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int scan_exp(input int k);
        logic [23:0] hi;
        hi = 24'hFEDCBA;
        if (k < 3) return k;
        return int'(hi[k*4 +: 4]);
    endfunction

    initial begin
        int beats;
        int exp_idx;
        int stall;
        bit seen_done;

        vecs[0] = '{3'd3, 24'h543210, 4'h3, 3'd3};
        vecs[1] = '{3'd0, 24'h543210, 4'h0, 3'd0};
        vecs[2] = '{3'd5, 24'h543210, 4'h5, 3'd5};
        vecs[3] = '{3'd7, 24'h543210, 4'h5, 3'd5};
        vecs[4] = '{3'd6, 24'h543210, 4'h5, 3'd5};
        vecs[5] = '{3'd1, 24'hFEDCBA, 4'hB, 3'd1};
        vecs[6] = '{3'd4, 24'hFEDCBA, 4'hE, 3'd4};

        bus.in_data   = 24'h543210;
        bus.sel       = '0;
        bus.mode      = 1'b0;
        bus.req       = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        check("reset_valid", int'(bus.out_valid), 0);
        check("reset_data", int'(bus.out_data), 0);
        check("reset_idx", int'(bus.out_idx), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // back-to-back direct loads, one beat per cycle
        for (int i = 0; i < 7; i++) begin
            bus.mode    = 1'b0;
            bus.req     = 1'b1;
            bus.sel     = vecs[i].sel;
            bus.in_data = vecs[i].in_data;
            tick();
            check($sformatf("vec%0d_valid", i), int'(bus.out_valid), 1);
            check($sformatf("vec%0d_data", i), int'(bus.out_data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_idx", i), int'(bus.out_idx), int'(vecs[i].exp_idx));
        end

        bus.req = 1'b0;
        tick();
        check("idle_valid_clears", int'(bus.out_valid), 0);

        // direct backpressure: held beat must not be overwritten
        bus.in_data = 24'h543210;
        bus.req     = 1'b1;
        bus.sel     = 3'd2;
        tick();
        bus.out_ready = 1'b0;
        bus.sel       = 3'd4;
        tick();
        tick();
        check("bp_valid_hold", int'(bus.out_valid), 1);
        check("bp_data_hold", int'(bus.out_data), 2);
        check("bp_idx_hold", int'(bus.out_idx), 2);
        bus.out_ready = 1'b1;
        bus.req       = 1'b0;
        tick();
        check("bp_release_clears", int'(bus.out_valid), 0);

        // start with mode=0 and req with mode=1 are both ignored
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        tick();
        bus.start = 1'b0;
        check("start_mode0_busy", int'(bus.busy), 0);
        bus.req  = 1'b1;
        bus.mode = 1'b1;
        tick();
        bus.req = 1'b0;
        check("req_mode1_valid", int'(bus.out_valid), 0);
        check("req_mode1_busy", int'(bus.busy), 0);

        // full scan at ready=1; in_data changes mid-scan and req is ignored while busy
        bus.in_data = 24'h543210;
        bus.mode    = 1'b1;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("scan_busy_rise", int'(bus.busy), 1);
        check("scan_first_no_valid", int'(bus.out_valid), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("scan_k%0d_valid", k), int'(bus.out_valid), 1);
            check($sformatf("scan_k%0d_idx", k), int'(bus.out_idx), k);
            check($sformatf("scan_k%0d_data", k), int'(bus.out_data), scan_exp(k));
            check($sformatf("scan_k%0d_done", k), int'(bus.done), (k == 5) ? 1 : 0);
            if (k == 1) begin
                bus.mode = 1'b0;
                bus.req  = 1'b1;
                bus.sel  = 3'd0;
            end
            if (k == 2) bus.in_data = 24'hFEDCBA;
        end
        bus.req = 1'b0;
        tick();
        check("scan_end_busy", int'(bus.busy), 0);
        check("scan_end_valid", int'(bus.out_valid), 0);
        check("scan_end_done", int'(bus.done), 0);

        // scan with ready held low for 3 cycles on the idx=2 beat
        bus.in_data   = 24'h543210;
        bus.mode      = 1'b1;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        beats     = 0;
        exp_idx   = 0;
        stall     = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
            tick();
            if (bus.out_valid) begin
                if (bus.out_idx == 3'd2 && stall < 3) begin
                    bus.out_ready = 1'b0;
                    stall++;
                end else begin
                    bus.out_ready = 1'b1;
                end
                #1;
                if (bus.out_ready) begin
                    check($sformatf("bps_idx%0d", exp_idx), int'(bus.out_idx), exp_idx);
                    check($sformatf("bps_data%0d", exp_idx), int'(bus.out_data), exp_idx);
                    beats++;
                    exp_idx++;
                    if (bus.out_idx == 3'd5) begin
                        check("bps_done", int'(bus.done), 1);
                        seen_done = 1'b1;
                    end
                end else begin
                    check("bps_hold_data", int'(bus.out_data), 2);
                    check("bps_hold_done", int'(bus.done), 0);
                end
            end
        end
        check("bps_seen_done", int'(seen_done), 1);
        check("bps_beats", beats, 6);
        check("bps_stalls", stall, 3);
        tick();
        check("bps_busy_low", int'(bus.busy), 0);

        // asynchronous reset in the middle of a scan
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", int'(bus.out_valid), 0);
        check("rst_mid_data", int'(bus.out_data), 0);
        check("rst_mid_idx", int'(bus.out_idx), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_after_busy", int'(bus.busy), 0);
        check("rst_after_valid", int'(bus.out_valid), 0);

`ifdef MUX_PARITY_EN
        bus.mode    = 1'b0;
        bus.req     = 1'b1;
        bus.in_data = 24'h000_09B;
        bus.sel     = 3'd0;
        tick();
        check("par_1011", int'(bus.out_par), 1);
        bus.sel = 3'd1;
        tick();
        check("par_1001", int'(bus.out_par), 0);
        bus.req = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
